// File: rtl/aes_key_sched_ctrl_pkg.sv
//==============================================================================
// Module  : aes_key_sched_ctrl_pkg
// Desc    : Shared constants, FSM encoding and S-box/rcon helpers for the
//           AES-128 key-schedule controller.
// Rev     : 1.0
//==============================================================================
`default_nettype none

package aes_key_sched_ctrl_pkg;

    localparam int c_aes_nr = 10;

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_expand = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE   = c_st_idle,
        ST_EXPAND = c_st_expand
    } state_t;

    // Row r holds S-box outputs for inputs 0xr0..0xrF, left to right.
    localparam logic [0:15][127:0] c_sbox_rows = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        logic [127:0] row;
        row = c_sbox_rows[b[7:4]];
        return row[{~b[3:0], 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_key_sched_ctrl_round_step.sv
//==============================================================================
// Module  : aes_key_round_step
// Desc    : Combinational AES-128 key-expansion step: previous round key and
//           round number in, next round key out.
// Rev     : 1.0
//==============================================================================
`default_nettype none

module aes_key_round_step
    import aes_key_sched_ctrl_pkg::*;
(
    input  logic [127:0] prev_key,
    input  logic [3:0]   rnd,
    output logic [127:0] next_key
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot, w_sub, w_t;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign w_w0  = prev_key[127:96];
    assign w_w1  = prev_key[95:64];
    assign w_w2  = prev_key[63:32];
    assign w_w3  = prev_key[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            assign w_sub[gi*8 +: 8] = aes_sbox(w_rot[gi*8 +: 8]);
        end
    endgenerate

    assign w_t  = w_sub ^ {aes_rcon(rnd), 24'h0};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign next_key = {w_n0, w_n1, w_n2, w_n3};

endmodule

`default_nettype wire

// File: rtl/aes_key_sched_ctrl.sv
//==============================================================================
// Module  : aes_key_sched_ctrl
// Desc    : Iterative AES-128 key-schedule controller; one round key per clock
//           into an 11-entry register file with a registered read port.
// Rev     : 1.0
//==============================================================================
`default_nettype none

module aes_key_sched_ctrl
    import aes_key_sched_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = c_aes_nr,
    parameter int RK_ADDR_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [127:0]         key_in,
    output logic                 start_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 keys_valid,
    input  logic [RK_ADDR_W-1:0] rk_addr,
    output logic [127:0]         rk_data
);

    localparam logic [3:0]           c_last_rnd = 4'(NUM_ROUNDS);
    localparam logic [RK_ADDR_W-1:0] c_max_addr = RK_ADDR_W'(NUM_ROUNDS);

    state_t       r_state;
    state_t       w_state_next;
    logic [3:0]   r_rnd;
    logic [3:0]   w_rnd_next;
    logic         r_done;
    logic         w_done_next;
    logic         r_keys_valid;
    logic         w_kv_next;
    logic         w_load_key;
    logic         w_write_round;
    logic [127:0] r_keys [0:NUM_ROUNDS];
    logic [127:0] r_rk_data;
    logic [3:0]   w_prev_idx;
    logic [127:0] w_prev_key;
    logic [127:0] w_next_key;

    assign w_prev_idx = r_rnd - 4'd1;
    assign w_prev_key = r_keys[w_prev_idx];

    aes_key_round_step u_round_step (
        .prev_key (w_prev_key),
        .rnd      (r_rnd),
        .next_key (w_next_key)
    );

    always_comb begin
        w_state_next  = r_state;
        w_rnd_next    = r_rnd;
        w_done_next   = 1'b0;
        w_kv_next     = r_keys_valid;
        w_load_key    = 1'b0;
        w_write_round = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load_key   = 1'b1;
                    w_state_next = ST_EXPAND;
                    w_rnd_next   = 4'd1;
                    w_kv_next    = 1'b0;
                end
            end
            ST_EXPAND: begin
                w_write_round = 1'b1;
                w_rnd_next    = r_rnd + 4'd1;
                if (r_rnd == c_last_rnd) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                    w_kv_next    = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_rnd        <= 4'd0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_rnd        <= w_rnd_next;
            r_done       <= w_done_next;
            r_keys_valid <= w_kv_next;
        end
    end

    // Entry 0 holds the cipher key itself; entries 1..10 are written in order.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                r_keys[i] <= '0;
            end
        end else if (w_load_key) begin
            r_keys[0] <= key_in;
        end else if (w_write_round) begin
            r_keys[r_rnd] <= w_next_key;
        end
    end

    // Read port is state-independent; consumers qualify with keys_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rk_data <= '0;
        end else if (rk_addr <= c_max_addr) begin
            r_rk_data <= r_keys[rk_addr];
        end else begin
            r_rk_data <= '0;
        end
    end

    assign start_ready = (r_state == ST_IDLE);
    assign busy        = (r_state == ST_EXPAND);
    assign done        = r_done;
    assign keys_valid  = r_keys_valid;
    assign rk_data     = r_rk_data;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_sched_ctrl.sv
//==============================================================================
// Module  : tb_aes_key_sched_ctrl
// Desc    : Scoreboard bench for aes_key_sched_ctrl with a GF(2^8)-derived
//           key-expansion reference model.
// Rev     : 1.0
//==============================================================================
`default_nettype none

module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key_in;
    logic         start_ready;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;

    always #5 clk = ~clk;

    aes_key_sched_ctrl #(
        .NUM_ROUNDS (10),
        .RK_ADDR_W  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .key_in      (key_in),
        .start_ready (start_ready),
        .busy        (busy),
        .done        (done),
        .keys_valid  (keys_valid),
        .rk_addr     (rk_addr),
        .rk_data     (rk_data)
    );

    int           n_cmp = 0;
    int           n_err = 0;
    logic [127:0] exp_q [$];
    logic         rd_req = 1'b0;
    logic [7:0]   sbox_m [0:255];
    logic [127:0] ref_k  [0:10];

    localparam logic [127:0] c_fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_fips_k1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_fips_k10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_zero_k1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] c_zero_k10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_model(input logic [127:0] key);
        logic [7:0]  rc;
        logic [31:0] w [0:3];
        logic [31:0] rot, t;
        ref_k[0] = key;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            for (int j = 0; j < 4; j++) w[j] = ref_k[r-1][127 - 32*j -: 32];
            rot = {w[3][23:0], w[3][31:24]};
            t = {sbox_m[rot[31:24]], sbox_m[rot[23:16]], sbox_m[rot[15:8]], sbox_m[rot[7:0]]}
                ^ {rc, 24'h0};
            w[0] = w[0] ^ t;
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            ref_k[r] = {w[0], w[1], w[2], w[3]};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_read(input int a, input logic [127:0] exp);
        rk_addr = 4'(a);
        exp_q.push_back(exp);
        rd_req = 1'b1;
    endtask

    // Monitor: a read requested before an edge is answered after that edge.
    initial begin
        logic v;
        forever begin
            @(posedge clk);
            v = rd_req;
            @(negedge clk);
            if (v) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rk_data: got %h with empty scoreboard", rk_data);
                end else begin
                    chk("rk_data", rk_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic run_expand(input logic [127:0] key, input bit hold,
                              input bit inject, input logic [127:0] alt);
        expand_model(key);
        start  = 1'b1;
        key_in = key;
        chk("start_ready_pre", 128'(start_ready), 128'd1);
        tick();
        rd_req = 1'b0;
        if (!hold) start = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            if (inject && e == 4) begin
                start  = 1'b1;
                key_in = alt;
            end
            if (inject && e == 5) start = 1'b0;
            tick();
            chk("busy",        128'(busy),        128'(e < 10));
            chk("done",        128'(done),        128'(e == 10));
            chk("keys_valid",  128'(keys_valid),  128'(e == 10));
            chk("start_ready", 128'(start_ready), 128'(e == 10));
        end
    endtask

    task automatic sweep();
        for (int a = 0; a <= 12; a++) begin
            issue_read(a, (a <= 10) ? ref_k[a] : 128'h0);
            tick();
            if (a == 0) chk("done_one_cycle", 128'(done), 128'd0);
        end
        rd_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [127:0] ka, kb, prev10;
        logic [127:0] kbb [0:2];

        reset   = 1'b1;
        start   = 1'b0;
        key_in  = '0;
        rk_addr = '0;
        build_sbox();
        tick();
        tick();
        chk("rst_start_ready", 128'(start_ready), 128'd1);
        chk("rst_busy",        128'(busy),        128'd0);
        chk("rst_done",        128'(done),        128'd0);
        chk("rst_keys_valid",  128'(keys_valid),  128'd0);
        chk("rst_rk_data",     rk_data,           128'd0);
        reset = 1'b0;
        tick();

        // FIPS-197 vector, full readback and literal round keys
        run_expand(c_fips_key, 1'b0, 1'b0, '0);
        sweep();
        issue_read(1, c_fips_k1);
        tick();
        issue_read(10, c_fips_k10);
        tick();
        rd_req = 1'b0;
        tick();

        // Start while busy is dropped; the blocked key is accepted later
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        run_expand(ka, 1'b0, 1'b1, kb);
        sweep();
        run_expand(kb, 1'b0, 1'b0, '0);
        sweep();

        // Back-to-back with start held high
        for (int i = 0; i < 3; i++) kbb[i] = {$urandom, $urandom, $urandom, $urandom};
        prev10 = '0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) issue_read(10, prev10);
            run_expand(kbb[i], 1'b1, 1'b0, '0);
            prev10 = ref_k[10];
        end
        start = 1'b0;
        sweep();

        // Reset part-way through an expansion
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy",        128'(busy),        128'd0);
        chk("midrst_keys_valid",  128'(keys_valid),  128'd0);
        chk("midrst_start_ready", 128'(start_ready), 128'd1);
        issue_read(3, 128'h0);
        tick();
        issue_read(0, 128'h0);
        tick();
        rd_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("midrst_no_done", 128'(done), 128'd0);
        end

        // All-zero key
        run_expand(128'h0, 1'b0, 1'b0, '0);
        sweep();
        issue_read(1, c_zero_k1);
        tick();
        issue_read(10, c_zero_k10);
        tick();
        rd_req = 1'b0;
        tick();

        // Random keys
        for (int i = 0; i < 3; i++) begin
            run_expand({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, '0);
            sweep();
        end

        tick();
        tick();
        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
